// File: rtl/spi_arbiter.sv
// Two-requester arbiter sharing one SPI core, with per-requester chip selects and bursts.
// Define SPI_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise req0 has fixed priority.
module spi_arbiter (
    input  logic        raw_clk,
    input  logic        reset_n,

    input  logic        req0,
    input  logic        req0_last,
    input  logic        req0_width_16,
    input  logic [15:0] req0_data,
    output logic        done0,

    input  logic        req1,
    input  logic        req1_last,
    input  logic        req1_width_16,
    input  logic [15:0] req1_data,
    output logic        done1,

    output logic [7:0]  rx_data,
    output logic        cs0_n,
    output logic        cs1_n,

    output logic        spi_start,
    output logic        spi_width_16,
    output logic [15:0] spi_data_tx,
    input  logic [7:0]  spi_data_rx,
    input  logic        spi_busy
);

    typedef enum logic [2:0] {
        StIdle,
        StCsSetup,
        StStart,
        StWaitBusy,
        StWaitDone,
        StHold,
        StCsRelease
    } state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic [15:0] tx_data_q, tx_data_d;
    logic        tx_w16_q, tx_w16_d;
    logic        last_q, last_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        cs0_n_q, cs0_n_d;
    logic        cs1_n_q, cs1_n_d;
    logic        cs_active;
`ifdef SPI_ARB_ROUND_ROBIN_EN
    logic        last_owner_q, last_owner_d;
`endif

    logic        own_req;
    logic        own_last;
    logic        own_w16;
    logic [15:0] own_data;

    assign own_req  = owner_q ? req1          : req0;
    assign own_last = owner_q ? req1_last     : req0_last;
    assign own_w16  = owner_q ? req1_width_16 : req0_width_16;
    assign own_data = owner_q ? req1_data     : req0_data;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        tx_data_d    = tx_data_q;
        tx_w16_d     = tx_w16_q;
        last_d       = last_q;
        rx_data_d    = rx_data_q;
        spi_start    = 1'b0;
        spi_data_tx  = tx_data_q;
        spi_width_16 = tx_w16_q;
        done0        = 1'b0;
        done1        = 1'b0;
`ifdef SPI_ARB_ROUND_ROBIN_EN
        last_owner_d = last_owner_q;
`endif

        case (state_q)
            StIdle: begin
                // The SPI core is not reset with us, so never grant while it is still busy.
                if (!spi_busy && (req0 || req1)) begin
`ifdef SPI_ARB_ROUND_ROBIN_EN
                    owner_d = (req0 && req1) ? ~last_owner_q : ~req0;
`else
                    owner_d = ~req0;
`endif
                    state_d = StCsSetup;
                end
            end
            StCsSetup: state_d = StStart;
            StStart: begin
                tx_data_d    = own_data;
                tx_w16_d     = own_w16;
                last_d       = own_last;
                spi_start    = 1'b1;
                spi_data_tx  = own_data;
                spi_width_16 = own_w16;
                state_d      = StWaitBusy;
            end
            StWaitBusy: begin
                if (spi_busy) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (!spi_busy) begin
                    rx_data_d = spi_data_rx;
                    done0     = ~owner_q;
                    done1     = owner_q;
                    state_d   = last_q ? StCsRelease : StHold;
                end
            end
            StHold: begin
                if (own_req) begin
                    state_d = StStart;
                end
            end
            StCsRelease: begin
`ifdef SPI_ARB_ROUND_ROBIN_EN
                last_owner_d = owner_q;
`endif
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Chip selects are registered from the next state so they never glitch.
        cs_active = (state_d == StCsSetup) || (state_d == StStart) || (state_d == StWaitBusy) ||
                    (state_d == StWaitDone) || (state_d == StHold);
        cs0_n_d   = ~(cs_active && !owner_d);
        cs1_n_d   = ~(cs_active && owner_d);
    end

    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            tx_data_q <= 16'h0000;
            tx_w16_q  <= 1'b0;
            last_q    <= 1'b0;
            rx_data_q <= 8'h00;
            cs0_n_q   <= 1'b1;
            cs1_n_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            tx_data_q <= tx_data_d;
            tx_w16_q  <= tx_w16_d;
            last_q    <= last_d;
            rx_data_q <= rx_data_d;
            cs0_n_q   <= cs0_n_d;
            cs1_n_q   <= cs1_n_d;
        end
    end

`ifdef SPI_ARB_ROUND_ROBIN_EN
    // Reset to 1 so the first tie after reset goes to requester 0.
    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) begin
            last_owner_q <= 1'b1;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`endif

    assign rx_data = rx_data_q;
    assign cs0_n   = cs0_n_q;
    assign cs1_n   = cs1_n_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed self-checking bench for spi_arbiter with a simple busy/rx model of the SPI core.
`timescale 1ns/1ps
module tb_spi_arbiter;

    logic        clk;
    logic        reset_n;
    logic        req0, req0_last, req0_width_16, done0;
    logic        req1, req1_last, req1_width_16, done1;
    logic [15:0] req0_data, req1_data;
    logic [7:0]  rx_data;
    logic        cs0_n, cs1_n;
    logic        spi_start, spi_width_16;
    logic [15:0] spi_data_tx;
    logic [7:0]  spi_data_rx;
    logic        spi_busy;

    spi_arbiter dut (
        .raw_clk       (clk),
        .reset_n       (reset_n),
        .req0          (req0),
        .req0_last     (req0_last),
        .req0_width_16 (req0_width_16),
        .req0_data     (req0_data),
        .done0         (done0),
        .req1          (req1),
        .req1_last     (req1_last),
        .req1_width_16 (req1_width_16),
        .req1_data     (req1_data),
        .done1         (done1),
        .rx_data       (rx_data),
        .cs0_n         (cs0_n),
        .cs1_n         (cs1_n),
        .spi_start     (spi_start),
        .spi_width_16  (spi_width_16),
        .spi_data_tx   (spi_data_tx),
        .spi_data_rx   (spi_data_rx),
        .spi_busy      (spi_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SPI core model: busy for 3 cycles after a start, never reset.
    int   busy_cnt = 0;
    logic hold_busy = 1'b0;
    always @(posedge clk) begin
        if (spi_start) busy_cnt <= 3;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign spi_busy = hold_busy || (busy_cnt != 0);

    int          checks = 0;
    int          errors = 0;
    int          start_cnt = 0, done0_cnt = 0, done1_cnt = 0, viol = 0;
    int          cs1_gap = 0, cs0_in_burst = 0;
    logic [15:0] last_tx = 16'h0;
    logic        last_w16 = 1'b0;
    logic        burst_on = 1'b0;

    always @(negedge clk) begin
        if (spi_start) begin
            start_cnt <= start_cnt + 1;
            last_tx   <= spi_data_tx;
            last_w16  <= spi_width_16;
        end
        if (done0) done0_cnt <= done0_cnt + 1;
        if (done1) done1_cnt <= done1_cnt + 1;
        if ((!cs0_n && !cs1_n) || (done0 && done1) || (done0 && cs0_n) || (done1 && cs1_n) ||
            (spi_start && (cs0_n == cs1_n)))
            viol <= viol + 1;
        if (burst_on && cs1_n) cs1_gap <= cs1_gap + 1;
        if (burst_on && !cs0_n) cs0_in_burst <= cs0_in_burst + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int idx, input string tag);
        int n;
        n = 0;
        while ((((idx == 0) ? done0 : done1) !== 1'b1) && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_done"}, 32'(n < 40), 32'd1);
    endtask

    task automatic wait_cs_low(input int idx, input string tag);
        int n;
        n = 0;
        while ((((idx == 0) ? cs0_n : cs1_n) !== 1'b0) && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_cs"}, 32'(n < 40), 32'd1);
    endtask

    task automatic wait_any_cs(input string tag);
        int n;
        n = 0;
        while (cs0_n === 1'b1 && cs1_n === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_any_cs"}, 32'(n < 40), 32'd1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        int s0, d0, d1, low_cnt, exp_owner;
        reset_n = 1'b0;
        req0 = 0; req0_last = 0; req0_width_16 = 0; req0_data = 16'h0;
        req1 = 0; req1_last = 0; req1_width_16 = 0; req1_data = 16'h0;
        spi_data_rx = 8'h00;
        tick();
        check("rst_cs0_n", 32'(cs0_n), 32'd1);
        check("rst_cs1_n", 32'(cs1_n), 32'd1);
        check("rst_start", 32'(spi_start), 32'd0);
        check("rst_w16", 32'(spi_width_16), 32'd0);
        check("rst_tx", 32'(spi_data_tx), 32'd0);
        check("rst_done", 32'({done1, done0}), 32'd0);
        check("rst_rx", 32'(rx_data), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Single byte transfer from requester 0.
        spi_data_rx = 8'h3C;
        req0 = 1; req0_last = 1; req0_width_16 = 0; req0_data = 16'h00A5;
        s0 = start_cnt; d0 = done0_cnt;
        tick();
        check("t1_setup_cs0", 32'(cs0_n), 32'd0);
        check("t1_setup_nostart", 32'(spi_start), 32'd0);
        check("t1_setup_cs1", 32'(cs1_n), 32'd1);
        tick();
        check("t1_start", 32'(spi_start), 32'd1);
        check("t1_tx", 32'(spi_data_tx), 32'h00A5);
        check("t1_w16", 32'(spi_width_16), 32'd0);
        tick();
        check("t1_start_gone", 32'(spi_start), 32'd0);
        check("t1_tx_held", 32'(spi_data_tx), 32'h00A5);
        wait_done(0, "t1");
        check("t1_no_done1", 32'(done1), 32'd0);
        req0 = 0; req0_last = 0;
        tick();
        check("t1_done_pulse", 32'(done0), 32'd0);
        check("t1_rx", 32'(rx_data), 32'h3C);
        check("t1_cs0_release", 32'(cs0_n), 32'd1);
        check("t1_starts", 32'(start_cnt - s0), 32'd1);
        check("t1_dones", 32'(done0_cnt - d0), 32'd1);
        tick();
        tick();

        // Three-word burst from requester 1, requester 0 interrupts mid-burst.
        spi_data_rx = 8'hC1;
        req1 = 1; req1_last = 0; req1_width_16 = 1; req1_data = 16'h1234;
        s0 = start_cnt; d1 = done1_cnt;
        wait_cs_low(1, "t2_grant");
        burst_on = 1'b1;
        wait_done(1, "t2_w1");
        check("t2_w1_tx", 32'(last_tx), 32'h1234);
        check("t2_w1_w16", 32'(last_w16), 32'd1);
        check("t2_rx_hold", 32'(rx_data), 32'h3C);
        req1_data = 16'h5678;
        tick();
        check("t2_rx_w1", 32'(rx_data), 32'hC1);
        req0 = 1; req0_last = 1; req0_width_16 = 0; req0_data = 16'h0F0F;
        spi_data_rx = 8'hC2;
        wait_done(1, "t2_w2");
        check("t2_w2_tx", 32'(last_tx), 32'h5678);
        req1_data = 16'h9ABC; req1_last = 1;
        tick();
        spi_data_rx = 8'hC3;
        wait_done(1, "t2_w3");
        check("t2_w3_tx", 32'(last_tx), 32'h9ABC);
        burst_on = 1'b0;
        req1 = 0; req1_last = 0;
        tick();
        check("t2_rel_cs1", 32'(cs1_n), 32'd1);
        check("t2_rel_cs0", 32'(cs0_n), 32'd1);
        check("t2_rx_w3", 32'(rx_data), 32'hC3);
        check("t2_starts", 32'(start_cnt - s0), 32'd3);
        check("t2_dones", 32'(done1_cnt - d1), 32'd3);
        check("t2_cs1_gap", 32'(cs1_gap), 32'd0);
        check("t2_cs0_blocked", 32'(cs0_in_burst), 32'd0);
        wait_done(0, "t2_req0");
        check("t2_req0_tx", 32'(last_tx), 32'h0F0F);
        req0 = 0; req0_last = 0;
        tick();
        tick();

        // Busy core blocks the grant.
        hold_busy = 1'b1;
        req0 = 1; req0_last = 1; req0_data = 16'h0077;
        s0 = start_cnt; low_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (!cs0_n) low_cnt++;
        end
        check("t3_no_cs", 32'(low_cnt), 32'd0);
        check("t3_no_start", 32'(start_cnt - s0), 32'd0);
        hold_busy = 1'b0;
        wait_cs_low(0, "t3_grant");
        wait_done(0, "t3");
        req0 = 0; req0_last = 0;
        tick();
        check("t3_starts", 32'(start_cnt - s0), 32'd1);
        tick();

        // Simultaneous requests twice after reset.
        do_reset();
        req0 = 1; req0_last = 1; req0_data = 16'h00AA;
        req1 = 1; req1_last = 1; req1_data = 16'h00BB; req1_width_16 = 0;
        wait_any_cs("t4_r1");
        check("t4_first_owner", 32'({cs1_n, cs0_n}), 32'b10);
        wait_done(0, "t4_r1");
        req0 = 0; req1 = 0;
        tick();
        tick();
        tick();
        req0 = 1; req1 = 1;
`ifdef SPI_ARB_ROUND_ROBIN_EN
        exp_owner = 1;
`else
        exp_owner = 0;
`endif
        wait_any_cs("t4_r2");
        check("t4_second_owner", 32'({cs1_n, cs0_n}), (exp_owner == 1) ? 32'b01 : 32'b10);
        wait_done(exp_owner, "t4_r2");
        req0 = 0; req1 = 0; req0_last = 0; req1_last = 0;
        tick();
        tick();

        // Reset during WAIT_DONE of a requester-0 transfer.
        spi_data_rx = 8'h77;
        req0 = 1; req0_last = 1; req0_data = 16'h0042;
        wait_cs_low(0, "t5_grant");
        low_cnt = 0;
        while (spi_busy !== 1'b1 && low_cnt < 20) begin
            tick();
            low_cnt++;
        end
        check("t5_busy_seen", 32'(low_cnt < 20), 32'd1);
        tick();
        d0 = done0_cnt;
        hold_busy = 1'b1;
        reset_n = 1'b0;
        #1;
        check("t5_cs0_async", 32'(cs0_n), 32'd1);
        check("t5_done0_off", 32'(done0), 32'd0);
        check("t5_rx_cleared", 32'(rx_data), 32'd0);
        req0 = 0; req0_last = 0;
        tick();
        tick();
        reset_n = 1'b1;
        spi_data_rx = 8'h5A;
        req1 = 1; req1_last = 1; req1_data = 16'hBEEF; req1_width_16 = 1;
        s0 = start_cnt; low_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!cs1_n) low_cnt++;
        end
        check("t5_wait_busy_cs", 32'(low_cnt), 32'd0);
        check("t5_wait_busy_start", 32'(start_cnt - s0), 32'd0);
        hold_busy = 1'b0;
        wait_cs_low(1, "t5_req1");
        wait_done(1, "t5_req1");
        req1 = 0; req1_last = 0;
        tick();
        check("t5_rx", 32'(rx_data), 32'h5A);
        check("t5_tx", 32'(last_tx), 32'hBEEF);
        check("t5_no_done0", 32'(done0_cnt - d0), 32'd0);
        tick();

        check("invariants", 32'(viol), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
